// File: rtl/ram_io_responder.sv
// Byte-wide RAM bus responder: on-chip byte RAM plus an I/O window with TX/RX FIFOs and status.
// Define CYCLE_COUNTER_EN to add a 32-bit cycle counter with a coherent 4-byte snapshot at 0x8-0xB.
module ram_io_responder #(
  parameter int RAM_AW  = 17,
  parameter int FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_rw,
  input  logic [31:0] ram_addr,
  input  logic [7:0]  ram_data,
  output logic [7:0]  ram_result,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        io_tx_full
);

  localparam int FD = 1 << FIFO_AW;

  logic [7:0] mem [0:(1 << RAM_AW) - 1];
  logic [7:0] tx_mem [0:FD-1];
  logic [7:0] rx_mem [0:FD-1];

  logic [FIFO_AW:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic             tx_ovf;
  logic [7:0]       rd_data;
  logic             unused_addr;

  logic is_io, io_wr, io_rd;
  logic [3:0] io_off;
  logic [RAM_AW-1:0] ram_a;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push_req, tx_push, tx_pop, rx_push, rx_pop, status_rd;

  assign unused_addr = ^ram_addr;

  // IO decode wins over RAM aliasing of the same low address bits
  assign is_io  = (ram_addr[17:16] == 2'b11);
  assign io_wr  = is_io && ram_rw;
  assign io_rd  = is_io && !ram_rw;
  assign io_off = ram_addr[3:0];
  assign ram_a  = ram_addr[RAM_AW-1:0];

  assign tx_empty = (tx_wr == tx_rd);
  assign tx_full  = (tx_wr[FIFO_AW-1:0] == tx_rd[FIFO_AW-1:0]) && (tx_wr[FIFO_AW] != tx_rd[FIFO_AW]);
  assign rx_empty = (rx_wr == rx_rd);
  assign rx_full  = (rx_wr[FIFO_AW-1:0] == rx_rd[FIFO_AW-1:0]) && (rx_wr[FIFO_AW] != rx_rd[FIFO_AW]);

  assign tx_push_req = io_wr && (io_off == 4'h0);
  assign tx_push     = tx_push_req && !tx_full;
  assign tx_pop      = tx_ready && !tx_empty;
  assign rx_push     = rx_valid && !rx_full;
  assign rx_pop      = io_rd && (io_off == 4'h0) && !rx_empty;
  assign status_rd   = io_rd && (io_off == 4'h4);

  assign tx_valid   = !tx_empty;
  assign tx_data    = tx_empty ? 8'h00 : tx_mem[tx_rd[FIFO_AW-1:0]];
  assign rx_ready   = !rx_full;
  assign io_tx_full = tx_full;

`ifdef CYCLE_COUNTER_EN
  logic [31:0] cyc_cnt, cyc_shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt    <= 32'h0;
      cyc_shadow <= 32'h0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'h1;
      if (io_rd && (io_off == 4'h8)) cyc_shadow <= cyc_cnt;
    end
  end
`endif

  always_comb begin
    rd_data = mem[ram_a];
    if (is_io) begin
      rd_data = 8'h00;
      case (io_off)
        4'h0: if (!rx_empty) rd_data = rx_mem[rx_rd[FIFO_AW-1:0]];
        4'h4: rd_data = {5'b0, tx_ovf, tx_full, !rx_empty};
`ifdef CYCLE_COUNTER_EN
        4'h8: rd_data = cyc_cnt[7:0];
        4'h9: rd_data = cyc_shadow[15:8];
        4'hA: rd_data = cyc_shadow[23:16];
        4'hB: rd_data = cyc_shadow[31:24];
`endif
        default: rd_data = 8'h00;
      endcase
    end
  end

  // Storage arrays carry no reset; reset only gates their writes
  always_ff @(posedge clk) begin
    if (!rst && !is_io && ram_rw) mem[ram_a] <= ram_data;
    if (!rst && tx_push) tx_mem[tx_wr[FIFO_AW-1:0]] <= ram_data;
    if (!rst && rx_push) rx_mem[rx_wr[FIFO_AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr      <= '0;
      tx_rd      <= '0;
      rx_wr      <= '0;
      rx_rd      <= '0;
      tx_ovf     <= 1'b0;
      ram_result <= 8'h00;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      if (tx_push_req && tx_full) tx_ovf <= 1'b1;
      else if (status_rd)         tx_ovf <= 1'b0;
      if (!ram_rw) ram_result <= rd_data;
    end
  end

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed self-checking bench for ram_io_responder; counter expectations follow CYCLE_COUNTER_EN.
module tb_ram_io_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        ram_rw;
  logic [31:0] ram_addr;
  logic [7:0]  ram_data;
  logic [7:0]  ram_result;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        io_tx_full;

  int checks = 0;
  int failures = 0;
  logic [31:0] tb_cnt;

  ram_io_responder dut (
    .clk(clk), .rst(rst), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_result(ram_result), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .io_tx_full(io_tx_full)
  );

  always #5 clk = ~clk;

  // Reference cycle count: cleared on reset edges, +1 on every other edge
  always @(posedge clk) begin
    if (rst) tb_cnt <= 32'h0;
    else     tb_cnt <= tb_cnt + 32'h1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    ram_rw = 1'b1; ram_addr = a; ram_data = d;
    step();
    ram_rw = 1'b0; ram_addr = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [7:0] got);
    ram_rw = 1'b0; ram_addr = a;
    step();
    got = ram_result;
    ram_addr = 32'h0;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    checks++; if (ram_result !== 8'h00) begin failures++; $display("FAIL reset_result got=%h exp=00", ram_result); end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL reset_rx_ready got=%b exp=1", rx_ready); end
    checks++; if (io_tx_full !== 1'b0) begin failures++; $display("FAIL reset_tx_full got=%b exp=0", io_tx_full); end
    rd(32'h30004, got);
    checks++; if (got !== 8'h00) begin failures++; $display("FAIL reset_status got=%h exp=00", got); end
  endtask

  task automatic test_ram_rw();
    logic [7:0] got;
    wr(32'h123, 8'hA5);
    rd(32'h123, got);
    checks++; if (got !== 8'hA5) begin failures++; $display("FAIL ram_rw got=%h exp=a5", got); end
    rd(32'h20123, got);
    checks++; if (got !== 8'hA5) begin failures++; $display("FAIL ram_alias_hi got=%h exp=a5", got); end
    rd(32'h40123, got);
    checks++; if (got !== 8'hA5) begin failures++; $display("FAIL ram_alias_wrap got=%h exp=a5", got); end
    ram_rw = 1'b1; ram_addr = 32'h124; ram_data = 8'h77;
    step();
    checks++; if (ram_result !== 8'hA5) begin failures++; $display("FAIL ram_hold_on_write got=%h exp=a5", ram_result); end
    ram_rw = 1'b0; ram_addr = 32'h0;
  endtask

  task automatic test_burst();
    logic [7:0] got;
    logic [7:0] pat [4];
    pat[0] = 8'h12; pat[1] = 8'h34; pat[2] = 8'h56; pat[3] = 8'h78;
    for (int i = 0; i < 4; i++) wr(32'h100 + i, pat[i]);
    for (int i = 0; i < 4; i++) begin
      rd(32'h100 + i, got);
      checks++; if (got !== pat[i]) begin failures++; $display("FAIL burst_rd[%0d] got=%h exp=%h", i, got, pat[i]); end
    end
  endtask

  task automatic test_tx_fifo();
    logic [7:0] got;
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      // last push uses nonzero bits 15:4, which the IO window ignores
      wr((i == 15) ? 32'h3ABC0 : 32'h30000, 8'h10 + 8'(i));
      if (i == 14) begin
        checks++; if (io_tx_full !== 1'b0) begin failures++; $display("FAIL tx_full_at15 got=%b exp=0", io_tx_full); end
      end
    end
    checks++; if (io_tx_full !== 1'b1) begin failures++; $display("FAIL tx_full_at16 got=%b exp=1", io_tx_full); end
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h10) begin failures++; $display("FAIL tx_head got=%b/%h exp=1/10", tx_valid, tx_data); end
    wr(32'h30000, 8'hEE);
    rd(32'h30004, got);
    checks++; if (got !== 8'h06) begin failures++; $display("FAIL status_ovf got=%h exp=06", got); end
    rd(32'h30004, got);
    checks++; if (got !== 8'h02) begin failures++; $display("FAIL status_ovf_clr got=%h exp=02", got); end
    // push into a full FIFO while a pop happens: the push is still dropped
    tx_ready = 1'b1;
    wr(32'h30000, 8'hEF);
    tx_ready = 1'b0;
    checks++; if (io_tx_full !== 1'b0 || tx_data !== 8'h11) begin failures++; $display("FAIL full_push_pop got=%b/%h exp=0/11", io_tx_full, tx_data); end
    rd(32'h30004, got);
    checks++; if (got !== 8'h04) begin failures++; $display("FAIL status_after_pop got=%h exp=04", got); end
    tx_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h10 + 8'(i)) begin
        failures++; $display("FAIL tx_drain[%0d] got=%b/%h exp=1/%h", i, tx_valid, tx_data, 8'h10 + 8'(i));
      end
      step();
    end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL tx_drained got=%b exp=0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    tx_ready = 1'b1;
    ram_rw = 1'b1; ram_addr = 32'h30000;
    for (int i = 0; i < 3; i++) begin
      ram_data = 8'hC0 + 8'(i);
      step();
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'hC0 + 8'(i)) begin
        failures++; $display("FAIL b2b[%0d] got=%b/%h exp=1/%h", i, tx_valid, tx_data, 8'hC0 + 8'(i));
      end
    end
    ram_rw = 1'b0; ram_addr = 32'h0;
    step();
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_io_misc();
    logic [7:0] got;
    wr(32'h30004, 8'hFF);
    wr(32'h30002, 8'hFF);
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL io_wr_ignored got=%b exp=0", tx_valid); end
    rd(32'h30002, got);
    checks++; if (got !== 8'h00) begin failures++; $display("FAIL io_off2 got=%h exp=00", got); end
    rd(32'h3000C, got);
    checks++; if (got !== 8'h00) begin failures++; $display("FAIL io_offC got=%h exp=00", got); end
    rd(32'h30004, got);
    checks++; if (got !== 8'h00) begin failures++; $display("FAIL io_status got=%h exp=00", got); end
  endtask

  task automatic test_counter();
    logic [7:0]  b [4];
    logic [31:0] exp_v, got_v;
    rd(32'h30008, b[0]);
`ifdef CYCLE_COUNTER_EN
    exp_v = tb_cnt - 32'h1;
`else
    exp_v = 32'h0;
`endif
    rd(32'h30009, b[1]);
    rd(32'h3000A, b[2]);
    rd(32'h3000B, b[3]);
    got_v = {b[3], b[2], b[1], b[0]};
    checks++; if (got_v !== exp_v) begin failures++; $display("FAIL counter got=%h exp=%h", got_v, exp_v); end
  endtask

  task automatic test_rx();
    logic [7:0] got;
    rd(32'h30000, got);
    checks++; if (got !== 8'h00) begin failures++; $display("FAIL rx_empty_rd got=%h exp=00", got); end
    rx_valid = 1'b1; rx_data = 8'h41;
    step();
    rx_valid = 1'b0;
    rd(32'h30004, got);
    checks++; if (got !== 8'h01) begin failures++; $display("FAIL rx_status1 got=%h exp=01", got); end
    rd(32'h30000, got);
    checks++; if (got !== 8'h41) begin failures++; $display("FAIL rx_pop got=%h exp=41", got); end
    rd(32'h30004, got);
    checks++; if (got !== 8'h00) begin failures++; $display("FAIL rx_status0 got=%h exp=00", got); end
    rx_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      rx_data = 8'h80 + 8'(i);
      step();
      if (i == 14) begin
        checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL rx_ready_at15 got=%b exp=1", rx_ready); end
      end
    end
    rx_valid = 1'b0;
    checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL rx_full got=%b exp=0", rx_ready); end
    rd(32'h30000, got);
    checks++; if (got !== 8'h80 || rx_ready !== 1'b1) begin failures++; $display("FAIL rx_full_pop got=%h/%b exp=80/1", got, rx_ready); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] got;
    wr(32'h200, 8'h3C);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(32'h30000, 8'h60 + 8'(i));
    rd(32'h200, got);
    checks++; if (got !== 8'h3C) begin failures++; $display("FAIL pre_rst_rd got=%h exp=3c", got); end
    rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h55;
    ram_rw = 1'b1; ram_addr = 32'h200; ram_data = 8'hFF;
    step();
    rst = 1'b0; rx_valid = 1'b0; ram_rw = 1'b0; ram_addr = 32'h0;
    checks++; if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_flags got=%b/%b exp=0/1", tx_valid, rx_ready); end
    checks++; if (ram_result !== 8'h00) begin failures++; $display("FAIL mid_rst_result got=%h exp=00", ram_result); end
    rd(32'h30004, got);
    checks++; if (got !== 8'h00) begin failures++; $display("FAIL mid_rst_status got=%h exp=00", got); end
    rd(32'h200, got);
    checks++; if (got !== 8'h3C) begin failures++; $display("FAIL mid_rst_ram got=%h exp=3c", got); end
  endtask

  initial begin
    rst = 1'b1; ram_rw = 1'b0; ram_addr = 32'h0; ram_data = 8'h00;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    #1;
    test_reset();
    test_ram_rw();
    test_burst();
    test_tx_fifo();
    test_back_to_back();
    test_io_misc();
    test_counter();
    test_rx();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_io_responder.md
# ram_io_responder

Responder end of the byte-wide RAM bus driven by the CPU memory controller. It decodes each cycle's address/rw/data into either the on-chip byte RAM or a small memory-mapped I/O window. The window holds a TX FIFO toward the host, an RX FIFO from the host, a status byte and an optional cycle counter. It returns read data with fixed one-cycle latency and never stalls the controller.

## Interface
Parameters:
- RAM_AW, 17: log2 of RAM depth in bytes; RAM occupies addresses 0 .. 2^RAM_AW-1 (aliased by low bits).
- FIFO_AW, 4: log2 of TX and RX FIFO depth (16 entries each).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ram_rw  in  1  1 = write, 0 = read; sampled every cycle.
- ram_addr  in  32  byte address.
- ram_data  in  8  write byte.
- ram_result  out  8  read byte; registered.
- tx_valid  out  1  TX FIFO non-empty.
- tx_data  out  8  TX FIFO head byte.
- tx_ready  in  1  host consumes head when tx_valid && tx_ready.
- rx_valid  in  1  host offers a byte.
- rx_data  in  8  offered byte.
- rx_ready  out  1  RX FIFO not full; push occurs when rx_valid && rx_ready.
- io_tx_full  out  1  TX FIFO full (for CPU-side throttling).

## Operation
- Decode: IO when ram_addr[17:16] == 2'b11; otherwise RAM at ram_addr[RAM_AW-1:0]. IO decode takes priority over RAM aliasing.
- RAM write: on the edge where ram_rw=1, mem[a] <= ram_data.
- RAM read: on the edge where ram_rw=0, ram_result <= mem[a].
- IO map, on ram_addr[3:0] with bits 15:4 ignored:
  - 0x0 write: push ram_data into the TX FIFO. If the FIFO is full, drop the byte and set sticky tx_ovf.
  - 0x0 read: if the RX FIFO is non-empty, return its head and pop it. If empty, return 0x00 and do not pop.
  - 0x4 read: status {5'b0, tx_ovf, tx_full, rx_nonempty}. Clears tx_ovf in the same edge. Write is ignored.
  - 0x8-0xB read: cycle counter bytes (see Configuration). Other offsets read 0x00 and ignore writes.
- FIFOs: circular, FIFO_AW-bit pointers plus one wrap bit each. full = pointers equal with wrap bits differing; empty = pointers equal with wrap bits equal.
- Simultaneous push and pop on the same FIFO in one edge are both performed, and the count is unchanged.
- Pop is blocked when the FIFO is empty. Push into a full FIFO is not performed, even if a pop happens in the same edge. rx_ready and io_tx_full are derived from registered pointers only.
- The controller issues a read every idle cycle at address 0. Because of this, address 0x30000 must never be hit by idle traffic. Reads to RAM have no side effects.

## Timing
- All state updates occur on the rising clk edge.
- Read latency is 1: an address sampled at edge k gives data on ram_result after edge k, held until edge k+1. This matches the controller capturing byte i one cycle after presenting address i.
- Writes take effect at the sampling edge. A read of the same address at edge k+1 returns the new byte.
- Reset (rst high at an edge): ram_result=0x00, both FIFOs empty, tx_valid=0, tx_data=0x00 (don't-care while invalid), rx_ready=1, io_tx_full=0, tx_ovf=0, counter=0. RAM contents are not reset.
- rst overrides every concurrent access. A host push or pop on a reset edge is discarded.
- tx_data/tx_valid reflect the new head one cycle after a pop or a push into an empty FIFO.

## Configuration
- CYCLE_COUNTER_EN defined: a 32-bit free-running counter increments every non-reset cycle.
  - Reading 0x8 snapshots the whole counter into a shadow register and returns byte 0.
  - Reads of 0x9/0xA/0xB return shadow bytes 1/2/3, so a 4-byte little-endian load is coherent.
- CYCLE_COUNTER_EN undefined: no counter or shadow logic; 0x8-0xB read 0x00.

## Test plan
- Write 0xA5 to 0x00000123, then read 0x00000123 the next cycle -> ram_result=0xA5 one cycle after the read address is sampled.
- 4-byte write of 0x12,0x34,0x56,0x78 to 0x100..0x103, then sequential reads -> 0x12,0x34,0x56,0x78 on consecutive cycles, each one cycle behind its address.
- 17 writes to 0x30000 with tx_ready=0:
  - io_tx_full=1 after the 16th.
  - The 17th is dropped; status read at 0x30004 returns 0x06.
  - A second status read returns 0x02.
  - Raising tx_ready drains the bytes in order.
- RX empty: read 0x30000 -> 0x00, no pop. Host pushes 0x41 -> status bit0=1; read 0x30000 -> 0x41; status bit0=0.
- rst asserted mid-stream with 5 TX bytes queued -> tx_valid=0, rx_ready=1, ram_result=0x00 after the edge; RAM byte written before reset still reads back.
- With CYCLE_COUNTER_EN: read 0x30008..0x3000B on consecutive cycles -> bytes form the counter value sampled at the 0x30008 edge. Without it: all four read 0x00.
